// File: rtl/heichips25_systolic_array_nxn.sv
// heichips25_systolic_array_nxn: N x N output-stationary systolic multiplier, C = A x W.
// Ports: clk; reset (synchronous, active-high); data_in/data_valid carry serial row-major
//   operand beats; load_weights/load_inputs/start are commands, accepted only in IDLE;
//   signed_mode/accumulate are sampled with start; result/result_valid/result_ready form
//   the row-major C output stream; busy, a one-cycle done pulse, and sticky overflow.
module heichips25_systolic_array_nxn #(
    parameter int N        = 2,
    parameter int BITWIDTH = 4,
    parameter int OUTWIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BITWIDTH-1:0] data_in,
    input  logic                data_valid,
    input  logic                load_weights,
    input  logic                load_inputs,
    input  logic                start,
    input  logic                signed_mode,
    input  logic                accumulate,
    output logic [OUTWIDTH-1:0] result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int EL = N * N;
    localparam int LW = $clog2(EL + 1);
    localparam int CW = $clog2(3 * N);
    localparam int XW = OUTWIDTH + 2;

    localparam logic [LW-1:0] LAST_EL  = LW'(EL - 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(3 * N - 3);

    localparam logic signed [XW-1:0] SMAX = {3'b000, {(OUTWIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = {3'b111, {(OUTWIDTH-1){1'b0}}};
    localparam logic signed [XW-1:0] UMAX = {2'b00, {OUTWIDTH{1'b1}}};

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, COMPUTE, OUTPUT} state_t;

    state_t state;

    logic [BITWIDTH-1:0] a_buf  [N][N];
    logic [BITWIDTH-1:0] w_buf  [N][N];
    logic [BITWIDTH-1:0] a_pipe [N][N-1];
    logic [BITWIDTH-1:0] w_pipe [N-1][N];
    logic [OUTWIDTH-1:0] acc    [N][N];

    logic [BITWIDTH-1:0] a_in   [N][N];
    logic [BITWIDTH-1:0] w_in   [N][N];
    logic [OUTWIDTH:0]   mac    [N][N];
    logic [BITWIDTH-1:0] a_feed [N];
    logic [BITWIDTH-1:0] w_feed [N];

    logic [LW-1:0]       ld_idx;
    logic [LW-1:0]       out_idx;
    logic [CW-1:0]       cnt;
    logic                sgn;
    logic                any_clamp;
    logic [OUTWIDTH-1:0] next_val;

    // Returns {clamped, acc + a*w}. Two guard bits keep the raw sum exact
    // in both signed and unsigned interpretation before clamping.
    function automatic logic [OUTWIDTH:0] sat_mac(
        input logic [OUTWIDTH-1:0] acc_v,
        input logic [BITWIDTH-1:0] a_v,
        input logic [BITWIDTH-1:0] w_v,
        input logic                sgn_v
    );
        logic signed [XW-1:0] ea;
        logic signed [XW-1:0] ex;
        logic signed [XW-1:0] ew;
        logic signed [XW-1:0] sum;
        logic [OUTWIDTH:0]    res;
        if (sgn_v) begin
            ea = {{2{acc_v[OUTWIDTH-1]}}, acc_v};
            ex = {{(XW-BITWIDTH){a_v[BITWIDTH-1]}}, a_v};
            ew = {{(XW-BITWIDTH){w_v[BITWIDTH-1]}}, w_v};
        end else begin
            ea = {2'b00, acc_v};
            ex = {{(XW-BITWIDTH){1'b0}}, a_v};
            ew = {{(XW-BITWIDTH){1'b0}}, w_v};
        end
        sum = ea + ex * ew;
        res = {1'b0, sum[OUTWIDTH-1:0]};
        if (sgn_v) begin
            if (sum > SMAX) begin
                res = {1'b1, SMAX[OUTWIDTH-1:0]};
            end else if (sum < SMIN) begin
                res = {1'b1, SMIN[OUTWIDTH-1:0]};
            end
        end else if (sum > UMAX) begin
            res = {1'b1, UMAX[OUTWIDTH-1:0]};
        end
        return res;
    endfunction

    // Edge injection: row r of A enters column 0 skewed by r cycles,
    // column c of W enters row 0 skewed by c cycles; zeros outside the window.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_feed[r] = '0;
            w_feed[r] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(cnt) == r + k) begin
                    a_feed[r] = a_buf[r][k];
                    w_feed[r] = w_buf[k][r];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = a_feed[i];
            end else begin : g_a_hop
                assign a_in[i][j] = a_pipe[i][j-1];
            end
            if (i == 0) begin : g_w_edge
                assign w_in[i][j] = w_feed[j];
            end else begin : g_w_hop
                assign w_in[i][j] = w_pipe[i-1][j];
            end
            assign mac[i][j] = sat_mac(acc[i][j], a_in[i][j], w_in[i][j], sgn);
        end
    end

    always_comb begin
        any_clamp = 1'b0;
        next_val  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                any_clamp = any_clamp | mac[i][j][OUTWIDTH];
                if (int'(out_idx) + 1 == i * N + j) begin
                    next_val = acc[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ld_idx       <= '0;
            out_idx      <= '0;
            cnt          <= '0;
            sgn          <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_buf[r][c] <= '0;
                    w_buf[r][c] <= '0;
                    acc[r][c]   <= '0;
                end
            end
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    a_pipe[r][c] <= '0;
                end
            end
            for (int r = 0; r < N - 1; r++) begin
                for (int c = 0; c < N; c++) begin
                    w_pipe[r][c] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_weights) begin
                        ld_idx <= '0;
                        busy   <= 1'b1;
                        state  <= LOAD_W;
                    end else if (load_inputs) begin
                        ld_idx <= '0;
                        busy   <= 1'b1;
                        state  <= LOAD_A;
                    end else if (start) begin
                        sgn   <= signed_mode;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= COMPUTE;
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N - 1; c++) begin
                                a_pipe[r][c] <= '0;
                            end
                        end
                        for (int r = 0; r < N - 1; r++) begin
                            for (int c = 0; c < N; c++) begin
                                w_pipe[r][c] <= '0;
                            end
                        end
                        if (!accumulate) begin
                            overflow <= 1'b0;
                            for (int r = 0; r < N; r++) begin
                                for (int c = 0; c < N; c++) begin
                                    acc[r][c] <= '0;
                                end
                            end
                        end
                    end
                end
                LOAD_W, LOAD_A: begin
                    if (data_valid) begin
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                if (int'(ld_idx) == r * N + c) begin
                                    if (state == LOAD_W) begin
                                        w_buf[r][c] <= data_in;
                                    end else begin
                                        a_buf[r][c] <= data_in;
                                    end
                                end
                            end
                        end
                        if (ld_idx == LAST_EL) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            ld_idx <= ld_idx + LW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            acc[r][c] <= mac[r][c][OUTWIDTH-1:0];
                        end
                    end
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N - 1; c++) begin
                            a_pipe[r][c] <= a_in[r][c];
                        end
                    end
                    for (int r = 0; r < N - 1; r++) begin
                        for (int c = 0; c < N; c++) begin
                            w_pipe[r][c] <= w_in[r][c];
                        end
                    end
                    if (any_clamp) begin
                        overflow <= 1'b1;
                    end
                    // PE(0,0) finished long before the last wavefront cycle.
                    if (cnt == LAST_CYC) begin
                        out_idx      <= '0;
                        result       <= mac[0][0][OUTWIDTH-1:0];
                        result_valid <= 1'b1;
                        state        <= OUTPUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                OUTPUT: begin
                    if (result_ready) begin
                        if (out_idx == LAST_EL) begin
                            result_valid <= 1'b0;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            out_idx <= out_idx + LW'(1);
                            result  <= next_val;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heichips25_systolic_array_nxn.sv
// tb_heichips25_systolic_array_nxn: randomized self-checking bench for the systolic array.
// Expected C values come from a plain-integer matrix model with per-MAC saturation.
module tb_heichips25_systolic_array_nxn;

    localparam int N  = 2;
    localparam int BW = 4;
    localparam int OW = 8;
    localparam int EL = N * N;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] data_in;
    logic          data_valid;
    logic          load_weights;
    logic          load_inputs;
    logic          start;
    logic          signed_mode;
    logic          accumulate;
    logic [OW-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    int aa [EL];
    int ww [EL];
    int ref_raw [EL];
    bit ref_ovf;

    logic [OW-1:0] got_q [$];
    int first_lat;
    int done_lat;

    always #5 clk = ~clk;

    heichips25_systolic_array_nxn #(
        .N(N), .BITWIDTH(BW), .OUTWIDTH(OW)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .load_weights(load_weights), .load_inputs(load_inputs), .start(start),
        .signed_mode(signed_mode), .accumulate(accumulate), .result(result),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy),
        .done(done), .overflow(overflow)
    );

    function automatic int as_int(input int raw, input int width, input bit sgn);
        if (sgn && (((raw >> (width - 1)) & 1) == 1)) return raw - (1 << width);
        return raw;
    endfunction

    task automatic model_clear();
        for (int e = 0; e < EL; e++) begin
            aa[e] = 0;
            ww[e] = 0;
            ref_raw[e] = 0;
        end
        ref_ovf = 0;
    endtask

    task automatic model_run(input bit sgn, input bit accum);
        int lo;
        int hi;
        int c;
        bit hit;
        hit = 0;
        lo = sgn ? -(1 << (OW - 1)) : 0;
        hi = sgn ? (1 << (OW - 1)) - 1 : (1 << OW) - 1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c = accum ? as_int(ref_raw[i*N+j], OW, sgn) : 0;
                for (int k = 0; k < N; k++) begin
                    c += as_int(aa[i*N+k], BW, sgn) * as_int(ww[k*N+j], BW, sgn);
                    if (c > hi) begin
                        c = hi;
                        hit = 1;
                    end else if (c < lo) begin
                        c = lo;
                        hit = 1;
                    end
                end
                ref_raw[i*N+j] = c & ((1 << OW) - 1);
            end
        end
        ref_ovf = accum ? (ref_ovf | hit) : hit;
    endtask

    task automatic clear_inputs();
        data_in      = '0;
        data_valid   = 1'b0;
        load_weights = 1'b0;
        load_inputs  = 1'b0;
        start        = 1'b0;
        signed_mode  = 1'b0;
        accumulate   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        model_clear();
    endtask

    task automatic load_mat(input bit is_w, input int vals [EL]);
        @(negedge clk);
        if (is_w) load_weights = 1'b1;
        else load_inputs = 1'b1;
        @(negedge clk);
        load_weights = 1'b0;
        load_inputs  = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL load_busy: busy=%b required 1", busy);
        end
        for (int e = 0; e < EL; e++) begin
            repeat ($urandom_range(0, 2)) begin
                data_in = BW'($urandom);
                @(negedge clk);
            end
            data_in    = BW'(vals[e]);
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL load_idle: busy=%b required 0", busy);
        end
        for (int e = 0; e < EL; e++) begin
            if (is_w) ww[e] = vals[e];
            else aa[e] = vals[e];
        end
    endtask

    task automatic run_op(input bit sgn, input bit accum, input int ready_pct,
                          input bit noise, input int hold);
        int hold_left;
        hold_left = hold;
        got_q.delete();
        first_lat = -1;
        done_lat  = -1;
        @(negedge clk);
        start       = 1'b1;
        signed_mode = sgn;
        accumulate  = accum;
        @(negedge clk);
        start       = 1'b0;
        signed_mode = 1'($urandom);
        accumulate  = 1'($urandom);
        model_run(sgn, accum);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL run_busy: busy=%b required 1", busy);
        end
        for (int t = 1; t < 200; t++) begin
            if (result_valid === 1'b1 && first_lat < 0) first_lat = t;
            if (done === 1'b1) begin
                done_lat = t;
                break;
            end
            if (hold_left > 0 && first_lat >= 0) begin
                result_ready = 1'b0;
                hold_left--;
                checks++;
                if (result_valid !== 1'b1 || result !== OW'(ref_raw[0])) begin
                    failures++;
                    $display("FAIL hold_stable: valid=%b result=%0h required 1/%0h",
                             result_valid, result, OW'(ref_raw[0]));
                end
            end else begin
                result_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (noise) begin
                load_weights = 1'($urandom);
                load_inputs  = 1'($urandom);
                start        = 1'($urandom);
                data_valid   = 1'($urandom);
                data_in      = BW'($urandom);
            end
            if (result_valid === 1'b1 && result_ready === 1'b1) got_q.push_back(result);
            @(negedge clk);
        end
        clear_inputs();
        checks++;
        if (done_lat < 0) begin
            failures++;
            $display("FAIL run_timeout: done never seen, required within 200 cycles");
        end
        checks++;
        if (got_q.size() != EL) begin
            failures++;
            $display("FAIL result_count: got %0d required %0d", got_q.size(), EL);
        end
        for (int e = 0; e < EL && e < got_q.size(); e++) begin
            checks++;
            if (got_q[e] !== OW'(ref_raw[e])) begin
                failures++;
                $display("FAIL result[%0d]: got %0h required %0h", e, got_q[e], OW'(ref_raw[e]));
            end
        end
        checks++;
        if (overflow !== ref_ovf) begin
            failures++;
            $display("FAIL overflow: got %b required %b", overflow, ref_ovf);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic check_latency();
        checks++;
        if (first_lat != 3 * N - 1) begin
            failures++;
            $display("FAIL first_valid_lat: got %0d required %0d", first_lat, 3 * N - 1);
        end
        checks++;
        if (done_lat != 3 * N - 1 + EL) begin
            failures++;
            $display("FAIL done_lat: got %0d required %0d", done_lat, 3 * N - 1 + EL);
        end
    endtask

    task automatic load_basic();
        int w [EL];
        int a [EL];
        w = '{1, 2, 3, 4};
        a = '{5, 6, 7, 8};
        load_mat(1'b1, w);
        load_mat(1'b0, a);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        result_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (result !== '0 || result_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: result=%0h valid=%b busy=%b done=%b ovf=%b required all 0",
                     result, result_valid, busy, done, overflow);
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_unsigned();
        load_basic();
        run_op(1'b0, 1'b0, 100, 1'b0, 0);
        check_latency();
        checks++;
        if (got_q.size() != EL || got_q[0] !== 8'd23 || got_q[EL-1] !== 8'd46) begin
            failures++;
            $display("FAIL unsigned_corners: got %p required 23 first and 46 last", got_q);
        end
    endtask

    task automatic test_signed();
        int w [EL];
        int a [EL];
        a = '{15, 2, 3, 12};
        w = '{1, 0, 0, 1};
        load_mat(1'b0, a);
        load_mat(1'b1, w);
        run_op(1'b1, 1'b0, 100, 1'b0, 0);
        check_latency();
    endtask

    task automatic test_saturation();
        int v [EL];
        v = '{15, 15, 15, 15};
        load_mat(1'b0, v);
        load_mat(1'b1, v);
        run_op(1'b0, 1'b0, 100, 1'b0, 0);
        v = '{8, 8, 8, 8};
        load_mat(1'b0, v);
        load_mat(1'b1, v);
        run_op(1'b1, 1'b0, 100, 1'b0, 0);
        checks++;
        if (overflow !== 1'b1 || got_q.size() != EL || got_q[0] !== 8'h7f) begin
            failures++;
            $display("FAIL signed_sat: ovf=%b first=%p required 1 and 7f", overflow, got_q);
        end
    endtask

    task automatic test_accumulate();
        load_basic();
        run_op(1'b0, 1'b0, 100, 1'b0, 0);
        run_op(1'b0, 1'b1, 100, 1'b0, 0);
        checks++;
        if (got_q.size() != EL || got_q[0] !== 8'd46 || got_q[EL-1] !== 8'd92) begin
            failures++;
            $display("FAIL accumulate_corners: got %p required 46 first and 92 last", got_q);
        end
    endtask

    task automatic test_backpressure();
        load_basic();
        run_op(1'b0, 1'b0, 100, 1'b0, 5);
        run_op(1'b0, 1'b0, 40, 1'b1, 0);
    endtask

    task automatic test_random();
        int v [EL];
        for (int it = 0; it < 8; it++) begin
            if (it == 0 || $urandom_range(0, 1) == 1) begin
                for (int e = 0; e < EL; e++) v[e] = int'($urandom_range(0, 15));
                load_mat(1'b1, v);
            end
            if (it == 0 || $urandom_range(0, 1) == 1) begin
                for (int e = 0; e < EL; e++) v[e] = int'($urandom_range(0, 15));
                load_mat(1'b0, v);
            end
            run_op(1'($urandom), 1'($urandom), int'($urandom_range(30, 100)), 1'b1, 0);
        end
    endtask

    task automatic test_reset_compute();
        load_basic();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_compute: busy=%b valid=%b required 0/0", busy, result_valid);
        end
        reset = 1'b0;
        run_op(1'b0, 1'b0, 100, 1'b0, 0);
    endtask

    task automatic test_reset_load();
        int a [EL];
        a = '{1, 2, 3, 4};
        @(negedge clk);
        load_weights = 1'b1;
        @(negedge clk);
        load_weights = 1'b0;
        for (int b = 0; b < 2; b++) begin
            data_in    = 4'd5;
            data_valid = 1'b1;
            @(negedge clk);
        end
        do_reset();
        reset = 1'b0;
        load_mat(1'b0, a);
        run_op(1'b0, 1'b0, 100, 1'b0, 0);
        checks++;
        if (got_q.size() != EL || got_q[0] !== 8'd0 || got_q[EL-1] !== 8'd0) begin
            failures++;
            $display("FAIL reset_load_zero: got %p required all zero", got_q);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_saturation();
        test_accumulate();
        test_backpressure();
        test_random();
        test_reset_compute();
        test_reset_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
